// File: rtl/game_timer_pkg.sv
// Shared types and default constants for the game countdown sequencer.
package game_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int DEF_TICK_DIV   = 5000;     // 50 MHz -> 0.1 ms
  localparam int DEF_START_TIME = 1800000;  // 180.0000 s in ticks
  localparam int DEF_PENALTY    = 10;
  localparam int DEF_BONUS      = 10;
  localparam int DEF_TW         = 21;
  localparam int DEF_PW         = 4;

endpackage

// File: rtl/game_timer_ctrl_tick_prescaler.sv
// Tick prescaler: counts 0..TICK_DIV-1 while enabled, strobes on the last count.
module tick_prescaler
  import game_timer_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_en & w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// Game countdown sequencer: run/pause/over FSM, remaining-time register, miss penalties.
// Optional hit bonus is enabled by defining GAME_TIMER_BONUS_EN.
module game_timer_ctrl
  import game_timer_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int START_TIME = DEF_START_TIME,
  parameter int PENALTY    = DEF_PENALTY,
  parameter int BONUS      = DEF_BONUS,
  parameter int TW         = DEF_TW,
  parameter int PW         = DEF_PW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_pause,
  input  logic          i_miss,
  input  logic          i_hit,
  output logic [TW-1:0] o_time_left,
  output logic          o_tick,
  output logic          o_running,
  output logic          o_game_over,
  output logic          o_miss_ovf
);

  localparam logic [TW-1:0] START_V  = TW'(START_TIME);
  localparam logic [TW-1:0] PEN_V    = TW'(PENALTY);
  localparam logic [PW-1:0] PEND_MAX = '1;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_time, w_time_nxt, w_ded;
  logic [PW-1:0] r_pend, w_pend_nxt, w_pend_dec;
  logic          r_ovf, w_ovf_nxt;
  logic          r_tick, r_running, r_game_over;
  logic          w_tick, w_en, w_clr;

  assign w_en = (r_state == ST_RUN);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_en),
    .i_clr   (w_clr),
    .o_tick  (w_tick)
  );

`ifdef GAME_TIMER_BONUS_EN
  logic [TW:0] w_sum;
`else
  logic w_hit_unused;
  assign w_hit_unused = i_hit & (BONUS != 0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_time_nxt  = r_time;
    w_pend_nxt  = r_pend;
    w_ovf_nxt   = r_ovf;
    w_clr       = 1'b0;
    w_ded       = TW'(1) + ((r_pend != '0) ? PEN_V : '0);
    w_pend_dec  = (w_tick && (r_pend != '0)) ? r_pend - PW'(1) : r_pend;
`ifdef GAME_TIMER_BONUS_EN
    w_sum       = '0;
`endif
    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
          w_time_nxt  = START_V;
          w_pend_nxt  = '0;
          w_ovf_nxt   = 1'b0;
          w_clr       = 1'b1;
        end
      end
      ST_RUN, ST_PAUSE: begin
        if (i_pause) w_state_nxt = (r_state == ST_RUN) ? ST_PAUSE : ST_RUN;
        // Saturation is judged after the tick has consumed its penalty.
        w_pend_nxt = w_pend_dec;
        if (i_miss) begin
          if (w_pend_dec == PEND_MAX) w_ovf_nxt = 1'b1;
          else                        w_pend_nxt = w_pend_dec + PW'(1);
        end
        if (w_tick) begin
          if (r_time <= w_ded) begin
            w_time_nxt  = '0;
            w_state_nxt = ST_OVER;
          end else begin
            w_time_nxt = r_time - w_ded;
          end
        end
`ifdef GAME_TIMER_BONUS_EN
        if (i_hit && (r_state == ST_RUN) && (w_state_nxt != ST_OVER)) begin
          w_sum      = {1'b0, w_time_nxt} + (TW+1)'(BONUS);
          w_time_nxt = (w_sum > {1'b0, START_V}) ? START_V : w_sum[TW-1:0];
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_time      <= '0;
      r_pend      <= '0;
      r_ovf       <= 1'b0;
      r_tick      <= 1'b0;
      r_running   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_time      <= w_time_nxt;
      r_pend      <= w_pend_nxt;
      r_ovf       <= w_ovf_nxt;
      r_tick      <= w_tick;
      r_running   <= (w_state_nxt == ST_RUN);
      r_game_over <= (w_state_nxt == ST_OVER);
    end
  end

  assign o_time_left = r_time;
  assign o_tick      = r_tick;
  assign o_running   = r_running;
  assign o_game_over = r_game_over;
  assign o_miss_ovf  = r_ovf;

endmodule
